div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring divider (DIV/DIVU), result {remainder, quotient}.
// Define DIV_ZERO_FLAG_EN to add the div_zero_out flag for zero-divisor requests.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic        signed_in,
    input  logic        annul_in,
    input  logic [31:0] opdata1_in,
    input  logic [31:0] opdata2_in,
    output logic [63:0] result_out,
    output logic        ready_out
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic        div_zero_out
`endif
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_d;
    logic [4:0]  cnt, cnt_d;
    logic [31:0] r, r_d, q, q_d, d, d_d;
    logic        neg_q, neg_q_d, neg_r, neg_r_d;
    logic [63:0] res_d;
    logic        rdy_d;
    logic [32:0] shifted, diff;
    logic [31:0] r_step, q_step;

    // q starts as the dividend magnitude and fills with quotient bits from the right
    assign shifted = {r, q[31]};
    assign diff    = shifted - {1'b0, d};
    assign r_step  = diff[32] ? shifted[31:0] : diff[31:0];
    assign q_step  = {q[30:0], ~diff[32]};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        r_d     = r;
        q_d     = q;
        d_d     = d;
        neg_q_d = neg_q;
        neg_r_d = neg_r;
        res_d   = result_out;
        rdy_d   = ready_out;
        case (state)
            FREE: if (start_in && !annul_in) begin
                if (opdata2_in == 32'd0) state_d = BYZERO;
                else begin
                    state_d = ON;
                    cnt_d   = 5'd0;
                    r_d     = 32'd0;
                    q_d     = (signed_in && opdata1_in[31]) ? -opdata1_in : opdata1_in;
                    d_d     = (signed_in && opdata2_in[31]) ? -opdata2_in : opdata2_in;
                    neg_q_d = signed_in && (opdata1_in[31] ^ opdata2_in[31]);
                    neg_r_d = signed_in && opdata1_in[31];
                end
            end
            BYZERO: begin
                state_d = annul_in ? FREE : END;
                rdy_d   = !annul_in;
                res_d   = 64'd0;
            end
            ON: if (annul_in) begin
                state_d = FREE;
                rdy_d   = 1'b0;
                res_d   = 64'd0;
            end else begin
                r_d = r_step;
                q_d = q_step;
                if (cnt == 5'd31) begin
                    state_d = END;
                    rdy_d   = 1'b1;
                    res_d   = {neg_r ? -r_step : r_step, neg_q ? -q_step : q_step};
                end else cnt_d = cnt + 5'd1;
            end
            END: if (!start_in) begin
                state_d = FREE;
                rdy_d   = 1'b0;
                res_d   = 64'd0;
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FREE;
            cnt        <= 5'd0;
            r          <= 32'd0;
            q          <= 32'd0;
            d          <= 32'd0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            result_out <= 64'd0;
            ready_out  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            r          <= r_d;
            q          <= q_d;
            d          <= d_d;
            neg_q      <= neg_q_d;
            neg_r      <= neg_r_d;
            result_out <= res_d;
            ready_out  <= rdy_d;
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    always_ff @(posedge clk)
        div_zero_out <= rst_n && ((state == BYZERO) ? !annul_in : (state == END) && start_in && div_zero_out);
`endif
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start_in, signed_in, annul_in;
    logic [31:0] opdata1_in, opdata2_in;
    logic [63:0] result_out;
    logic        ready_out;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_out;
`endif
    int pass_cnt = 0, total_cnt = 0;

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .signed_in(signed_in),
        .annul_in(annul_in), .opdata1_in(opdata1_in), .opdata2_in(opdata2_in),
        .result_out(result_out), .ready_out(ready_out)
`ifdef DIV_ZERO_FLAG_EN
        , .div_zero_out(div_zero_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            qq = a / b;
            rr = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            qq = a;
            rr = 32'd0;
        end else begin
            qq = $signed(a) / $signed(b);
            rr = $signed(a) % $signed(b);
        end
        return {rr, qq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        opdata1_in = a;
        opdata2_in = b;
        signed_in  = s;
        start_in   = 1'b1;
    endtask

    // edges are counted with the sampling edge as the first one
    task automatic finish_div(input logic zero, input logic [63:0] exp);
        int n = 0;
        do begin
            tick();
            n++;
            opdata1_in = $urandom;
            opdata2_in = $urandom;
            signed_in  = 1'($urandom);
        end while (!ready_out && n < 40);
        check("latency", 64'(n), zero ? 64'd2 : 64'd33);
        check("result", result_out, exp);
`ifdef DIV_ZERO_FLAG_EN
        check("div_zero", {63'd0, div_zero_out}, {63'd0, zero});
`endif
        annul_in = 1'b1;
        tick();
        check("hold_ready", {63'd0, ready_out}, 64'd1);
        check("hold_result", result_out, exp);
        annul_in = 1'b0;
        start_in = 1'b0;
        tick();
        check("clear_ready", {63'd0, ready_out}, 64'd0);
        check("clear_result", result_out, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("clear_div_zero", {63'd0, div_zero_out}, 64'd0);
`endif
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s, seen;
        rst_n = 1'b0; start_in = 1'b0; signed_in = 1'b0; annul_in = 1'b0;
        opdata1_in = 32'd0; opdata2_in = 32'd0;
        tick();
        tick();
        check("reset_ready", {63'd0, ready_out}, 64'd0);
        check("reset_result", result_out, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset_div_zero", {63'd0, div_zero_out}, 64'd0);
`endif
        rst_n = 1'b1;
        launch(32'd100, 32'd7, 1'b0);
        finish_div(1'b0, {32'd2, 32'd14});
        launch(32'hFFFFFFF9, 32'd2, 1'b1);
        finish_div(1'b0, {32'hFFFFFFFF, 32'hFFFFFFFD});
        launch(32'hFFFFFFF9, 32'd2, 1'b0);
        finish_div(1'b0, {32'h1, 32'h7FFFFFFC});
        launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
        finish_div(1'b0, {32'h0, 32'h80000000});
        launch(32'd12345, 32'd0, 1'b1);
        finish_div(1'b1, 64'd0);

        launch(32'd100, 32'd7, 1'b0);
        repeat (11) tick();
        annul_in = 1'b1;
        start_in = 1'b0;
        tick();
        check("annul_ready", {63'd0, ready_out}, 64'd0);
        check("annul_result", result_out, 64'd0);
        annul_in = 1'b0;
        seen = 1'b0;
        repeat (35) begin
            tick();
            seen |= ready_out;
        end
        check("annul_quiet", {63'd0, seen}, 64'd0);
        launch(32'd9, 32'd3, 1'b0);
        finish_div(1'b0, {32'd0, 32'd3});

        launch(32'd5, 32'd0, 1'b0);
        tick();
        annul_in = 1'b1;
        start_in = 1'b0;
        tick();
        check("annul_byzero_ready", {63'd0, ready_out}, 64'd0);
        annul_in = 1'b0;
        tick();
        check("annul_byzero_quiet", {63'd0, ready_out}, 64'd0);

        launch(32'hDEADBEEF, 32'd1234, 1'b1);
        repeat (21) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_ready", {63'd0, ready_out}, 64'd0);
        check("midreset_result", result_out, 64'd0);
        rst_n = 1'b1;
        launch(32'hDEADBEEF, 32'd1234, 1'b1);
        finish_div(1'b0, model(32'hDEADBEEF, 32'd1234, 1'b1));

        repeat (24) begin
            a = $urandom;
            case ($urandom_range(3))
                0: b = 32'd0;
                1: b = $urandom_range(15);
                2: b = -$urandom_range(15);
                default: b = $urandom;
            endcase
            s = 1'($urandom);
            launch(a, b, s);
            finish_div(b == 32'd0, model(a, b, s));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
